// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch slice: default widths, queue entry
// layout and the redirect-select encoding used by if_fetch_queue.
package if_pkg;

    localparam int AW_DEF = 16;
    localparam int IW_DEF = 16;

    // Prefetch queue entry at the default widths: fetched word plus its PC.
    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [AW_DEF-1:0] pc;
    } if_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CALL,
        SEL_BRANCH,
        SEL_RET
    } redir_sel_t;

    // Fixed redirect priority: call beats branch beats ret.
    function automatic redir_sel_t redir_select(input logic call,
                                                input logic branch,
                                                input logic ret);
        if (call)   return SEL_CALL;
        if (branch) return SEL_BRANCH;
        if (ret)    return SEL_RET;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/if_ras.sv
// Return-address stack: circular storage, top pointer and saturating depth.
// A push when full overwrites the oldest entry. Contents are discarded on rst
// by clearing the depth; the storage itself needs no reset.
module if_ras #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    output logic [AW-1:0] top,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DEPTH + 1);

    logic [AW-1:0] stack [DEPTH];
    logic [PW-1:0] ptr;       // next slot to write
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;   // slot holding the current top
    logic [DW-1:0] depth;

    assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);
    assign top     = stack[ptr_dec];
    assign empty   = (depth == '0);

    // Pointer and depth bookkeeping; push takes precedence over pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            depth <= '0;
        end else if (push) begin
            ptr   <= ptr_inc;
            depth <= (depth == DW'(DEPTH)) ? depth : depth + DW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            depth <= depth - DW'(1);
        end
    end

    // Stack storage write.
    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= push_addr;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous imem with
// at most one request in flight, and buffers responses in a prefetch queue
// that drains to decode over valid/ready. Any redirect flushes queued and
// in-flight work. Optional feature macro: IF_RAS_EN (internal return-address
// stack supplying ret targets).
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int IW        = IW_DEF,
    parameter int QDEPTH    = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          call,
    input  logic          branch,
    input  logic          ret,
    input  logic [AW-1:0] pc_call,
    input  logic [AW-1:0] pc_branch,
    input  logic [AW-1:0] pc_ret,
    input  logic [AW-1:0] ras_push_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_pc_inc,
    output logic          ras_empty
);

    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = QAW + 1;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic [AW-1:0]  fpc;
    logic [AW-1:0]  req_pc;    // PC of the request currently in flight
    logic [AW-1:0]  target;
    logic           infl;
    logic [CW-1:0]  count;
    logic [QAW-1:0] rd_ptr;
    logic [QAW-1:0] wr_ptr;
    entry_t         queue [QDEPTH];
    entry_t         head;
    redir_sel_t     sel;
    logic           redirect;
    logic           push;
    logic           pop;

    assign sel      = redir_select(call, branch, ret);
    assign redirect = (sel != SEL_NONE);
    assign out_valid = (count != '0);
    assign pop      = out_valid & out_ready;
    // A response arriving alongside a redirect is wrong-path and is dropped.
    assign push     = infl & ~redirect;
    // Reserving a slot for the in-flight word keeps the queue from overflowing.
    assign imem_req  = ~rst & ~redirect & ((count + CW'(infl)) < CW'(QDEPTH));
    assign imem_addr = fpc;

`ifdef IF_RAS_EN
    logic [AW-1:0] ras_top;
    logic          ras_pop;

    // Call+ret together: call wins, so the stack only pushes.
    assign ras_pop = (sel == SEL_RET) & ~ras_empty;

    if_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (call),
        .push_addr (ras_push_addr),
        .pop       (ras_pop),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{ras_push_addr, (RAS_DEPTH > 0)};
    assign ras_empty  = 1'b1;
`endif

    // Redirect target selection.
    always_comb begin
        // NOTE: default first so every path assigns target and no latch is inferred.
        target = pc_ret;
        case (sel)
            SEL_CALL:   target = pc_call;
            SEL_BRANCH: target = pc_branch;
`ifdef IF_RAS_EN
            SEL_RET:    target = ras_empty ? pc_ret : ras_top;
`else
            SEL_RET:    target = pc_ret;
`endif
            default:    target = pc_ret;
        endcase
    end

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fpc    <= '0;
            req_pc <= '0;
            infl   <= 1'b0;
        end else begin
            infl <= imem_req;
            if (redirect) begin
                fpc <= target;
            end else if (imem_req) begin
                fpc    <= fpc + AW'(1);
                req_pc <= fpc;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QAW'(1);
            if (pop)  rd_ptr <= rd_ptr + QAW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read, so stale data never escapes.
        if (push) queue[wr_ptr] <= '{instr: imem_rdata, pc: req_pc};
    end

    assign head       = queue[rd_ptr];
    assign out_instr  = out_valid ? head.instr : '0;
    assign out_pc     = out_valid ? head.pc : '0;
    assign out_pc_inc = out_pc + AW'(1);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: a per-cycle vector table for the
// startup / backpressure sequence, hand sequences for redirects, wrap and
// reset, and a scoreboard of expected head PCs checked on every handshake.
module tb_if_fetch_queue;

    localparam int AW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          call, branch, ret;
    logic [AW-1:0] pc_call, pc_branch, pc_ret, ras_push_addr;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          out_valid, out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc, out_pc_inc;
    logic          ras_empty;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_target;
    logic [AW-1:0] imem_addr_q = '0;

    typedef struct {
        logic          ready;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vecs [$];

    if_fetch_queue #(
        .AW(AW), .IW(IW), .QDEPTH(4), .RAS_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call          (call),
        .branch        (branch),
        .ret           (ret),
        .pc_call       (pc_call),
        .pc_branch     (pc_branch),
        .pc_ret        (pc_ret),
        .ras_push_addr (ras_push_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_inc    (out_pc_inc),
        .ras_empty     (ras_empty)
    );

    always #5 clk = ~clk;

    // Synchronous imem model: word for address A is A ^ 16'hA5A5, one cycle later.
    always @(posedge clk) imem_addr_q <= imem_addr;
    assign imem_rdata = imem_addr_q ^ 16'hA5A5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input logic [AW-1:0] start);
        logic [AW-1:0] v;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            v = start + AW'(i);
            exp_q.push_back(v);
        end
    endtask

    // Scoreboard: every accepted head must be the next expected PC; redirects
    // (after consuming any same-cycle pop) restart the stream at the target.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        logic [AW-1:0] e_inc;
        if (rst) begin
            fill('0);
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e     = exp_q.pop_front();
                    e_inc = e + AW'(1);
                    check("sb_pc", 32'(out_pc), 32'(e));
                    check("sb_instr", 32'(out_instr), 32'(e ^ 16'hA5A5));
                    check("sb_pc_inc", 32'(out_pc_inc), 32'(e_inc));
                end
            end
            if (call || branch || ret) fill(exp_target);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one redirect cycle and check the following fetch goes to 'tgt'.
    task automatic do_redirect(input logic c, input logic b, input logic r,
                               input logic [AW-1:0] pcc, input logic [AW-1:0] pcb,
                               input logic [AW-1:0] pcr, input logic [AW-1:0] push_a,
                               input logic [AW-1:0] tgt, input string name);
        call = c; branch = b; ret = r;
        pc_call = pcc; pc_branch = pcb; pc_ret = pcr; ras_push_addr = push_a;
        exp_target = tgt;
        @(negedge clk);
        check({name, "_req_in_redirect"}, 32'(imem_req), 32'd0);
        step();
        call = 1'b0; branch = 1'b0; ret = 1'b0;
        @(negedge clk);
        check({name, "_req"}, 32'(imem_req), 32'd1);
        check({name, "_addr"}, 32'(imem_addr), 32'(tgt));
        check({name, "_flushed"}, 32'(out_valid), 32'd0);
        step();
    endtask

    function automatic vec_t mk(input logic rdy, input logic req, input int addr,
                                input logic vld, input int pc);
        vec_t v;
        v.ready     = rdy;
        v.exp_req   = req;
        v.exp_addr  = AW'(addr);
        v.exp_valid = vld;
        v.exp_pc    = AW'(pc);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic found;

        rst = 1'b1; call = 1'b0; branch = 1'b0; ret = 1'b0;
        pc_call = '0; pc_branch = '0; pc_ret = '0; ras_push_addr = '0;
        out_ready = 1'b1; exp_target = '0;

        // Startup stream, backpressure to full, then release (cycles 1..20).
        vecs.push_back(mk(1, 1, 0,  0, 0));
        vecs.push_back(mk(1, 1, 1,  0, 0));
        vecs.push_back(mk(1, 1, 2,  1, 0));
        vecs.push_back(mk(1, 1, 3,  1, 1));
        vecs.push_back(mk(1, 1, 4,  1, 2));
        vecs.push_back(mk(0, 1, 5,  1, 3));
        vecs.push_back(mk(0, 1, 6,  1, 3));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0,  1, 3));
        vecs.push_back(mk(1, 1, 7,  1, 4));
        vecs.push_back(mk(1, 1, 8,  1, 5));
        vecs.push_back(mk(1, 1, 9,  1, 6));
        vecs.push_back(mk(1, 1, 10, 1, 7));

        step();
        step();
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_out_pc_inc", 32'(out_pc_inc), 32'd1);
        check("rst_ras_empty", 32'(ras_empty), 32'd1);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            out_ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vecs[i].exp_pc));
            step();
        end

        // Fill the queue, then branch while full with a same-cycle pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b1;
        do_redirect(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040, "branch");
        @(negedge clk);
        check("branch_no_stale", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("branch_valid_n3", 32'(out_valid), 32'd1);
        check("branch_pc_n3", 32'(out_pc), 32'h0040);
        step();

        // Call and branch together: call wins.
        do_redirect(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0100, "call_branch");
        for (int i = 0; i < 5; i++) step();

`ifndef IF_RAS_EN
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0099, 16'h0055, 16'h0099, "ret_noras");
        check("noras_empty", 32'(ras_empty), 32'd1);
        for (int i = 0; i < 3; i++) step();
`endif

        // PC wrap-around at 0xFFFF.
        do_redirect(1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE, "wrap");
        @(negedge clk);
        check("wrap_addr_ffff", 32'(imem_addr), 32'h0000FFFF);
        step();
        @(negedge clk);
        check("wrap_addr_0000", 32'(imem_addr), 32'h00000000);
        step();
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_pc == 16'hFFFF) begin
                found = 1'b1;
                check("wrap_pc_inc", 32'(out_pc_inc), 32'h00000000);
            end
            step();
        end
        if (!found) check("wrap_head_ffff_seen", 32'd0, 32'd1);

        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_pc_inc", 32'(out_pc_inc), 32'd1);
        check("midrst_ras_empty", 32'(ras_empty), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_first_req", 32'(imem_req), 32'd1);
        check("midrst_first_addr", 32'(imem_addr), 32'd0);
        step();
        for (int i = 0; i < 4; i++) step();

`ifdef IF_RAS_EN
        do_redirect(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0000, 16'h0000, 16'h0011, 16'h0500, "ras_call1");
        do_redirect(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h0000, 16'h0022, 16'h0600, "ras_call2");
        check("ras_nonempty", 32'(ras_empty), 32'd0);
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0099, 16'h0000, 16'h0022, "ras_ret1");
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0099, 16'h0000, 16'h0011, "ras_ret2");
        check("ras_empty_after_pops", 32'(ras_empty), 32'd1);
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0099, 16'h0000, 16'h0099, "ras_ret3");
        // Call and ret together: call target, stack only pushes.
        do_redirect(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h0099, 16'h0033, 16'h0300, "ras_call_ret");
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0099, 16'h0000, 16'h0033, "ras_ret_cr");
        check("ras_empty_cr", 32'(ras_empty), 32'd1);
        // Five pushes into four entries: oldest is overwritten.
        for (int i = 1; i <= 5; i++)
            do_redirect(1'b1, 1'b0, 1'b0, AW'(16'h0700 + i), 16'h0000, 16'h0000,
                        AW'(16'h00A0 + i), AW'(16'h0700 + i), $sformatf("ras_ovf_call%0d", i));
        for (int i = 5; i >= 2; i--)
            do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0077, 16'h0000,
                        AW'(16'h00A0 + i), $sformatf("ras_ovf_ret%0d", i));
        check("ras_ovf_empty", 32'(ras_empty), 32'd1);
        do_redirect(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0077, 16'h0000, 16'h0077, "ras_ovf_ret_empty");
        for (int i = 0; i < 4; i++) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage that owns the program counter, drives a synchronous instruction memory, and buffers fetched instructions in a prefetch queue. The queue drains to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage. It accepts call/branch/return redirects from later stages, and redirects flush all wrong-path work. An optional internal return-address stack supplies return targets.

## Interface
- AW, 16, PC/address width
- IW, 16, instruction width
- QDEPTH, 4, prefetch queue entries; power of two, ≥2
- RAS_DEPTH, 4, return-address-stack entries (used only with IF_RAS_EN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- call, branch, ret  in  1 each  redirect requests; priority call > branch > ret
- pc_call, pc_branch, pc_ret  in  AW each  redirect targets
- ras_push_addr  in  AW  return address pushed on call (ignored without IF_RAS_EN)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  AW  fetch address (= fetch PC)
- imem_rdata  in  IW  instruction, valid the cycle after imem_req
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  IW  head instruction
- out_pc, out_pc_inc  out  AW each  head PC and head PC+1 (mod 2^AW)
- ras_empty  out  1  RAS empty (constant 1 without IF_RAS_EN)

## Operation
- State: fetch PC `fpc`, in-flight flag `infl` (≤1 outstanding request), queue storing {instr, pc}, count 0..QDEPTH.
- Issue: imem_req = !rst & !redirect & (count + infl < QDEPTH). On issue, fpc ← fpc+1 (wraps at 2^AW) and infl ← 1 for the next cycle.
- Response: when infl, imem_rdata is written into the queue with its tag PC. It is dropped if a redirect occurs in the same cycle.
- Pop: out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (any of call/branch/ret): fpc ← selected target; queue count ← 0; infl ← 0; no request that cycle. A pop in the same cycle counts as consumed, and the queue is still emptied.
- Target with IF_RAS_EN: ret with RAS non-empty uses the RAS top and pops it; ret with RAS empty uses pc_ret.
- Call + ret in the same cycle: call wins; RAS only pushes.
- Arithmetic is unsigned AW-bit with wrap-around; the count is clog2(QDEPTH)+1 bits.

## Timing
- Reset values: fpc=0, infl=0, count=0, imem_req=0 during rst, out_valid=0, out_instr/out_pc=0, out_pc_inc=1, ras_empty=1.
- First request is in the first cycle after rst deasserts, with addr 0.
- Latency: request in cycle t → queue write at end of t+1 → out_valid in t+2.
- Redirect in cycle N → imem_req with target in N+1 → out_valid with out_pc=target in N+3.
- Full queue: imem_req=0 until a pop frees a slot. The in-flight reservation prevents overflow.
- rst mid-operation discards the queue, in-flight data, and RAS contents immediately.
- With out_ready held high and no redirects, sustained throughput is 1 instruction/cycle.

## Configuration
- IF_RAS_EN defined: RAS_DEPTH-entry circular stack.
  - Call pushes ras_push_addr.
  - Push when full overwrites the oldest entry; depth saturates at RAS_DEPTH.
  - Ret pops as described under Operation.
- IF_RAS_EN undefined: no stack; ret always targets pc_ret; ras_push_addr is ignored; ras_empty=1.

## Structure
- Shared package `if_pkg`:
  - AW/IW defaults
  - typedef of the queue entry struct {instr, pc}
  - redirect-select enum (NONE, CALL, BRANCH, RET)
- One sub-module: `if_ras` (stack storage, pointer, depth counter), instantiated under IF_RAS_EN.

## Test plan
- Reset then out_ready=1 and imem returning instr=addr^16'hA5A5 → out_pc 0,1,2,3… from the third post-reset cycle, one per cycle, out_instr matching.
- out_ready=0 for 10 cycles → count reaches 4, imem_req=0 thereafter. Release → 4 queued entries emerge in order with no gap, then fetch resumes.
- branch=1, pc_branch=16'h0040 while queue is full → next out_valid shows out_pc=0x0040 exactly 3 cycles later; no stale entries emerge.
- call and branch in the same cycle (pc_call=0x100, pc_branch=0x200) → fetch resumes at 0x100.
- fpc at 16'hFFFF → next fetch at 0x0000; out_pc_inc for head 0xFFFF is 0x0000.
- IF_RAS_EN: calls with ras_push_addr 0x11, 0x22, then ret with pc_ret=0x99 → target 0x22; a second ret → 0x11; a third ret (RAS empty) → 0x99. Five pushes into a 4-entry RAS → pops return 5th, 4th, 3rd, 2nd, then empty.
